// File: rtl/pipe_stage_skid_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush and an optional
// 2-entry skid buffer. It also merges trap and overflow conditions into the exception cause.
module pipe_stage_skid_reg #(
    parameter int unsigned       DATA_W      = 256,
    parameter int unsigned       CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] CTRL_RST    = '0,
    parameter bit                SKID        = 1'b1,
    parameter bit                CAUSE_MERGE = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [4:0]        i_except_cause,
    input  logic              i_is_trap,
    input  logic              i_trap_cond,
    input  logic              i_overflow,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [4:0]        o_except_cause,
    output logic [1:0]        o_occupancy
);

    localparam logic [4:0] ExcCauseTrap = 5'd13;
    localparam logic [4:0] ExcCauseOv   = 5'd12;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              accept, drain;
    logic              load_main, load_skid, skid_to_main;
    logic [4:0]        cause_in;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [4:0]        main_cause_q, skid_cause_q;

    always_comb begin
        cause_in = i_except_cause;
        if (CAUSE_MERGE) begin
            if (i_is_trap && i_trap_cond) begin
                cause_in = ExcCauseTrap;
            end else if (i_overflow) begin
                cause_in = ExcCauseOv;
            end
        end
    end

    assign o_valid = (state_q != StEmpty);
    // Skid variant registers ready; the single-entry variant passes downstream ready through.
    assign o_ready = SKID ? ready_q : (!o_valid || i_ready);
    assign accept  = i_valid && o_ready;
    assign drain   = o_valid && i_ready;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d   = StOne;
                    load_main = 1'b1;
                end
            end
            StOne: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (accept && SKID) begin
                    state_d   = StTwo;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (drain) begin
                    state_d      = StOne;
                    skid_to_main = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (i_flush) begin
            state_d      = StEmpty;
            load_main    = 1'b0;
            load_skid    = 1'b0;
            skid_to_main = 1'b0;
        end
    end

    assign ready_d = (state_d != StTwo);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StEmpty;
            ready_q      <= 1'b1;
            main_data_q  <= '0;
            main_ctrl_q  <= CTRL_RST;
            main_cause_q <= '0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= CTRL_RST;
            skid_cause_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            if (load_main) begin
                main_data_q  <= i_data;
                main_ctrl_q  <= i_ctrl;
                main_cause_q <= cause_in;
            end else if (skid_to_main) begin
                main_data_q  <= skid_data_q;
                main_ctrl_q  <= skid_ctrl_q;
                main_cause_q <= skid_cause_q;
            end
            if (load_skid) begin
                skid_data_q  <= i_data;
                skid_ctrl_q  <= i_ctrl;
                skid_cause_q <= cause_in;
            end
        end
    end

    assign o_data         = main_data_q;
    assign o_ctrl         = o_valid ? main_ctrl_q : CTRL_RST;
    assign o_except_cause = main_cause_q;
    assign o_occupancy    = (state_q == StTwo) ? 2'd2 : ((state_q == StOne) ? 2'd1 : 2'd0);

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: a SKID=1 and a SKID=0 instance share stimulus; each has a
// scoreboard queue checked on every drain, plus directed checks per scenario.
module tb_pipe_stage_skid_reg;

    localparam logic [7:0] CtrlRst = 8'hA5;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  ctrl;
        logic [4:0]  cause;
    } ent_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_valid, i_ready, i_flush, i_is_trap, i_trap_cond, i_overflow;
    logic [31:0] i_data;
    logic [7:0]  i_ctrl;
    logic [4:0]  i_except_cause;

    logic        a_ready, a_valid, b_ready, b_valid;
    logic [31:0] a_data, b_data;
    logic [7:0]  a_ctrl, b_ctrl;
    logic [4:0]  a_cause, b_cause;
    logic [1:0]  a_occ, b_occ;

    int   nvec = 0;
    int   nerr = 0;
    ent_t qa[$];
    ent_t qb[$];
    ent_t ea, eb;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(
        .DATA_W(32), .CTRL_W(8), .CTRL_RST(CtrlRst), .SKID(1'b1), .CAUSE_MERGE(1'b1)
    ) u_skid (
        .clk(clk), .resetn(resetn), .i_valid(i_valid), .o_ready(a_ready),
        .i_data(i_data), .i_ctrl(i_ctrl), .i_except_cause(i_except_cause),
        .i_is_trap(i_is_trap), .i_trap_cond(i_trap_cond), .i_overflow(i_overflow),
        .i_flush(i_flush), .o_valid(a_valid), .i_ready(i_ready), .o_data(a_data),
        .o_ctrl(a_ctrl), .o_except_cause(a_cause), .o_occupancy(a_occ)
    );

    pipe_stage_skid_reg #(
        .DATA_W(32), .CTRL_W(8), .CTRL_RST(CtrlRst), .SKID(1'b0), .CAUSE_MERGE(1'b1)
    ) u_single (
        .clk(clk), .resetn(resetn), .i_valid(i_valid), .o_ready(b_ready),
        .i_data(i_data), .i_ctrl(i_ctrl), .i_except_cause(i_except_cause),
        .i_is_trap(i_is_trap), .i_trap_cond(i_trap_cond), .i_overflow(i_overflow),
        .i_flush(i_flush), .o_valid(b_valid), .i_ready(i_ready), .o_data(b_data),
        .o_ctrl(b_ctrl), .o_except_cause(b_cause), .o_occupancy(b_occ)
    );

    function automatic logic [4:0] exp_cause(input logic t, input logic c, input logic o,
                                             input logic [4:0] ca);
        if (t && c) return 5'd13;
        if (o) return 5'd12;
        return ca;
    endfunction

    // Inputs change 1 time unit after posedge, so the negedge sees what the next edge will use.
    always @(negedge clk) begin
        if (!resetn) begin
            qa.delete();
        end else begin
            if (a_valid && i_ready) begin
                nvec++;
                if (qa.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_skid unexpected entry got %h want none", a_data);
                end else begin
                    ea = qa.pop_front();
                    if ({a_data, a_ctrl, a_cause} !== ea) begin
                        nerr++;
                        $display("FAIL sb_skid got %h want %h", {a_data, a_ctrl, a_cause}, ea);
                    end
                end
            end
            if (i_flush) qa.delete();
            else if (i_valid && a_ready)
                qa.push_back({i_data, i_ctrl,
                              exp_cause(i_is_trap, i_trap_cond, i_overflow, i_except_cause)});
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            qb.delete();
        end else begin
            if (b_valid && i_ready) begin
                nvec++;
                if (qb.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_single unexpected entry got %h want none", b_data);
                end else begin
                    eb = qb.pop_front();
                    if ({b_data, b_ctrl, b_cause} !== eb) begin
                        nerr++;
                        $display("FAIL sb_single got %h want %h", {b_data, b_ctrl, b_cause}, eb);
                    end
                end
            end
            if (i_flush) qb.delete();
            else if (i_valid && b_ready)
                qb.push_back({i_data, i_ctrl,
                              exp_cause(i_is_trap, i_trap_cond, i_overflow, i_except_cause)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
        i_is_trap = 1'b0; i_trap_cond = 1'b0; i_overflow = 1'b0;
        i_data = '0; i_ctrl = '0; i_except_cause = '0;
        step();
        nvec++;
        if ({a_valid, a_ready, a_occ, a_data, a_ctrl, a_cause} !== {1'b0, 1'b1, 2'd0, 32'd0, CtrlRst, 5'd0}) begin
            nerr++;
            $display("FAIL reset_skid got v=%b r=%b occ=%0d d=%h c=%h x=%0d want 0 1 0 0 a5 0",
                     a_valid, a_ready, a_occ, a_data, a_ctrl, a_cause);
        end
        nvec++;
        if ({b_valid, b_ready, b_occ, b_data, b_ctrl, b_cause} !== {1'b0, 1'b1, 2'd0, 32'd0, CtrlRst, 5'd0}) begin
            nerr++;
            $display("FAIL reset_single got v=%b r=%b occ=%0d d=%h c=%h x=%0d want 0 1 0 0 a5 0",
                     b_valid, b_ready, b_occ, b_data, b_ctrl, b_cause);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_stream();
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            i_valid = 1'b1; i_data = 32'(k); i_ctrl = 8'(k + 16); i_except_cause = 5'(k);
            step();
            nvec++;
            if (a_valid !== 1'b1 || a_data !== 32'(k) || a_occ !== 2'd1) begin
                nerr++;
                $display("FAIL stream_%0d got v=%b d=%h occ=%0d want 1 %h 1",
                         k, a_valid, a_data, a_occ, k);
            end
        end
        i_valid = 1'b0;
        step();
        nvec++;
        if (a_valid !== 1'b0 || a_occ !== 2'd0) begin
            nerr++;
            $display("FAIL stream_end got v=%b occ=%0d want 0 0", a_valid, a_occ);
        end
    endtask

    task automatic test_skid_fill();
        i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA; i_ctrl = 8'h0A;
        step();
        i_data = 32'hB; i_ctrl = 8'h0B;
        step();
        i_valid = 1'b0;
        step();
        nvec++;
        if (a_occ !== 2'd2 || a_ready !== 1'b0 || a_data !== 32'hA) begin
            nerr++;
            $display("FAIL skid_full got occ=%0d r=%b d=%h want 2 0 a", a_occ, a_ready, a_data);
        end
        i_ready = 1'b1;
        step();
        nvec++;
        if (a_valid !== 1'b1 || a_data !== 32'hB || a_occ !== 2'd1 || a_ready !== 1'b1) begin
            nerr++;
            $display("FAIL skid_drain1 got v=%b d=%h occ=%0d r=%b want 1 b 1 1",
                     a_valid, a_data, a_occ, a_ready);
        end
        step();
        nvec++;
        if (a_valid !== 1'b0 || a_occ !== 2'd0) begin
            nerr++;
            $display("FAIL skid_drain2 got v=%b occ=%0d want 0 0", a_valid, a_occ);
        end
    endtask

    task automatic test_cause();
        logic [3:0] row [4];
        logic [4:0] want [4];
        row[0] = 4'b0111; want[0] = 5'd13;
        row[1] = 4'b0001; want[1] = 5'd12;
        row[2] = 4'b0000; want[2] = 5'd4;
        row[3] = 4'b0110; want[3] = 5'd13;
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_data = 32'(k + 32'h100); i_except_cause = 5'd4;
            {i_is_trap, i_trap_cond, i_overflow} = row[k][2:0];
            if (k == 3) i_overflow = 1'b0;
            step();
            nvec++;
            if (a_cause !== want[k] || b_cause !== want[k]) begin
                nerr++;
                $display("FAIL cause_%0d got %0d/%0d want %0d", k, a_cause, b_cause, want[k]);
            end
        end
        i_valid = 1'b0; i_is_trap = 1'b0; i_trap_cond = 1'b0; i_overflow = 1'b0;
        step();
    endtask

    task automatic test_flush();
        i_ready = 1'b0; i_valid = 1'b1; i_ctrl = 8'h3C;
        i_data = 32'h21;
        step();
        i_data = 32'h22;
        step();
        nvec++;
        if (a_occ !== 2'd2) begin
            nerr++;
            $display("FAIL flush_pre got occ=%0d want 2", a_occ);
        end
        i_flush = 1'b1; i_data = 32'h23;
        step();
        nvec++;
        if (a_valid !== 1'b0 || a_ctrl !== CtrlRst || a_occ !== 2'd0 || a_ready !== 1'b1) begin
            nerr++;
            $display("FAIL flush got v=%b c=%h occ=%0d r=%b want 0 a5 0 1",
                     a_valid, a_ctrl, a_occ, a_ready);
        end
        nvec++;
        if (b_valid !== 1'b0 || b_ctrl !== CtrlRst || b_occ !== 2'd0) begin
            nerr++;
            $display("FAIL flush_single got v=%b c=%h occ=%0d want 0 a5 0", b_valid, b_ctrl, b_occ);
        end
        i_flush = 1'b0; i_valid = 1'b0;
        step();
        nvec++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            nerr++;
            $display("FAIL flush_discard got v=%b/%b want 0/0", a_valid, b_valid);
        end
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b0; i_valid = 1'b1; i_data = 32'h54; i_ctrl = 8'h54;
        step();
        i_ready = 1'b1; i_data = 32'h55; i_ctrl = 8'h55;
        #1;
        nvec++;
        if (b_valid !== 1'b1 || b_ready !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_ready got v=%b r=%b want 1 1", b_valid, b_ready);
        end
        step();
        nvec++;
        if (b_valid !== 1'b1 || b_data !== 32'h55 || b_occ !== 2'd1) begin
            nerr++;
            $display("FAIL b2b_data got v=%b d=%h occ=%0d want 1 55 1", b_valid, b_data, b_occ);
        end
        i_data = 32'h56; i_ctrl = 8'h56;
        step();
        nvec++;
        if (b_valid !== 1'b1 || b_data !== 32'h56) begin
            nerr++;
            $display("FAIL b2b_nobubble got v=%b d=%h want 1 56", b_valid, b_data);
        end
    endtask

    task automatic test_async_reset();
        i_ready = 1'b1; i_valid = 1'b1; i_data = 32'h77; i_ctrl = 8'h77;
        step();
        #2;
        resetn = 1'b0;
        #1;
        nvec++;
        if (a_valid !== 1'b0 || a_ctrl !== CtrlRst || a_occ !== 2'd0 || a_data !== 32'd0) begin
            nerr++;
            $display("FAIL async_skid got v=%b c=%h occ=%0d d=%h want 0 a5 0 0",
                     a_valid, a_ctrl, a_occ, a_data);
        end
        nvec++;
        if (b_valid !== 1'b0 || b_ctrl !== CtrlRst) begin
            nerr++;
            $display("FAIL async_single got v=%b c=%h want 0 a5", b_valid, b_ctrl);
        end
        step();
        resetn = 1'b1; i_valid = 1'b0;
        step();
        nvec++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_ready !== 1'b1) begin
            nerr++;
            $display("FAIL async_after got v=%b/%b r=%b want 0/0 1", a_valid, b_valid, a_ready);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid_fill();
        test_cause();
        test_flush();
        test_back_to_back();
        test_async_reset();
        step();
        nvec++;
        if (qa.size() != 0 || qb.size() != 0) begin
            nerr++;
            $display("FAIL sb_leftover got %0d/%0d want 0/0", qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
